// File: rtl/rx_frame_checker.sv
// Rx frame buffer and CRC-8 gate: stores one frame, checks its trailing CRC byte,
// and replays good frames without the CRC byte; drops and counts everything else.
module rx_frame_checker #(
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = $clog2(BUF_DEPTH),
    parameter int MIN_LEN   = 2
) (
    input  logic            clk_32M768,
    input  logic            rst_n_32M768,
    input  logic [7:0]      s_tdata,
    input  logic            s_tvalid,
    output logic            s_tready,
    input  logic            s_tlast,
    input  logic            s_tuser,
    output logic [7:0]      m_tdata,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            m_tlast,
    output logic            m_tuser,
    output logic [ADDR_W:0] frame_len,
    output logic [15:0]     ok_cnt,
    output logic [15:0]     err_cnt,
    output logic [1:0]      err_code
);

    localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LEN_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] LEN_FULL = (ADDR_W+1)'(BUF_DEPTH);
    localparam logic [ADDR_W:0] LEN_MIN  = (ADDR_W+1)'(MIN_LEN);
    localparam logic [1:0] ERR_CRC   = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_SHORT = 2'b11;

    typedef enum logic [2:0] {IDLE, RECV, DROP, CHECK, SEND} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     len;
    logic [7:0]          crc;
    logic                ovf;
    logic [ADDR_W-1:0]   rd_ptr_p0;
    logic [7:0]          mem [BUF_DEPTH];
    logic [7:0]          rd_data_p1;
    logic                vld_p1, last_p1, user_p1;

    logic                s_acc, m_hs;
    logic                restart, abandon, store, ovf_set, rd_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic                chk_fail;
    logic [1:0]          chk_code;

    // CRC-8, poly 0x07, MSB first, one byte per call
    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign s_tready = (state == IDLE) || (state == RECV) || (state == DROP);
    assign s_acc    = s_tvalid && s_tready;
    assign m_hs     = vld_p1 && m_tready;

    always_comb begin
        chk_fail = 1'b1;
        chk_code = ERR_OVF;
        if (ovf)
            chk_code = ERR_OVF;
        else if (len < LEN_MIN)
            chk_code = ERR_SHORT;
        else if (crc != 8'h00)
            chk_code = ERR_CRC;
        else
            chk_fail = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        abandon   = 1'b0;
        store     = 1'b0;
        ovf_set   = 1'b0;
        rd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (s_acc && s_tuser) begin
                    restart   = 1'b1;
                    state_nxt = s_tlast ? CHECK : RECV;
                end
            end
            RECV: begin
                if (s_acc) begin
                    if (s_tuser) begin
                        restart   = 1'b1;
                        abandon   = 1'b1;
                        state_nxt = s_tlast ? CHECK : RECV;
                    end else if (len == LEN_FULL) begin
                        ovf_set   = 1'b1;
                        state_nxt = s_tlast ? CHECK : DROP;
                    end else begin
                        store = 1'b1;
                        if (s_tlast)
                            state_nxt = CHECK;
                    end
                end
            end
            DROP: begin
                if (s_acc && s_tlast)
                    state_nxt = CHECK;
            end
            CHECK: state_nxt = chk_fail ? IDLE : SEND;
            SEND: begin
                // first SEND cycle prefetches address 0; afterwards each handshake fetches the next byte
                if (!vld_p1)
                    rd_en = 1'b1;
                else if (m_hs) begin
                    if (last_p1)
                        state_nxt = IDLE;
                    else
                        rd_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we   = restart || store;
    assign mem_addr = (state == SEND) ? rd_ptr_p0 : (restart ? '0 : len[ADDR_W-1:0]);

    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            state     <= IDLE;
            len       <= '0;
            crc       <= 8'h00;
            ovf       <= 1'b0;
            rd_ptr_p0 <= '0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            user_p1   <= 1'b0;
            frame_len <= '0;
            ok_cnt    <= 16'h0000;
            err_cnt   <= 16'h0000;
            err_code  <= 2'b00;
        end else begin
            state <= state_nxt;
            if (restart) begin
                len <= LEN_ONE;
                crc <= crc8_upd(8'h00, s_tdata);
                ovf <= 1'b0;
            end else if (store) begin
                len <= len + LEN_ONE;
                crc <= crc8_upd(crc, s_tdata);
            end
            if (ovf_set)
                ovf <= 1'b1;
            if (abandon) begin
                err_cnt  <= sat_inc16(err_cnt);
                err_code <= ERR_SHORT;
            end
            if (state == CHECK) begin
                rd_ptr_p0 <= '0;
                if (chk_fail) begin
                    err_cnt  <= sat_inc16(err_cnt);
                    err_code <= chk_code;
                end else begin
                    ok_cnt    <= sat_inc16(ok_cnt);
                    frame_len <= len - LEN_ONE;
                end
            end
            // p0 -> p1: read pointer stage to output register stage
            if (rd_en) begin
                rd_ptr_p0 <= rd_ptr_p0 + ADDR_W'(1);
                vld_p1    <= 1'b1;
                user_p1   <= (rd_ptr_p0 == '0);
                last_p1   <= ({1'b0, rd_ptr_p0} == len - LEN_TWO);
            end else if (m_hs) begin
                vld_p1  <= 1'b0;
                user_p1 <= 1'b0;
                last_p1 <= 1'b0;
            end
        end
    end

    // single-port buffer with registered read
    always_ff @(posedge clk_32M768) begin
        if (mem_we)
            mem[mem_addr] <= s_tdata;
        if (rd_en)
            rd_data_p1 <= mem[mem_addr];
    end

    assign m_tvalid = vld_p1;
    assign m_tdata  = vld_p1 ? rd_data_p1 : 8'h00;
    assign m_tlast  = last_p1;
    assign m_tuser  = user_p1;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Bench for rx_frame_checker: directed frames plus randomized traffic against a frame-level model.
module tb_rx_frame_checker;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_32M768   = 1'b0;
    logic          rst_n_32M768 = 1'b0;
    logic [7:0]    s_tdata  = 8'h00;
    logic          s_tvalid = 1'b0;
    logic          s_tlast  = 1'b0;
    logic          s_tuser  = 1'b0;
    logic          s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;
    logic [AW:0]   frame_len;
    logic [15:0]   ok_cnt, err_cnt;
    logic [1:0]    err_code;

    rx_frame_checker #(.BUF_DEPTH(DEPTH), .MIN_LEN(2)) dut (
        .clk_32M768(clk_32M768), .rst_n_32M768(rst_n_32M768),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .frame_len(frame_len), .ok_cnt(ok_cnt), .err_cnt(err_cnt), .err_code(err_code)
    );

    always #5 clk_32M768 = ~clk_32M768;

    typedef struct {
        logic [7:0] d;
        logic       u;
        logic       l;
        int         flen;
    } exp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    logic [7:0] out_log[$];
    logic [7:0] fbuf[$];
    int         n_out  = 0;
    bit         bp_en  = 0;
    bit         gap_en = 0;

    logic [7:0] cur[$];
    bit         in_frame = 0;
    bit         movf     = 0;
    int         m_ok = 0, m_err = 0, m_code = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // bit-serial CRC-8 (poly 0x07, init 0, MSB first)
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_end();
        logic [7:0] c;
        int         n;
        in_frame = 0;
        n = cur.size();
        if (movf) begin
            m_err = sat(m_err); m_code = 2;
        end else if (n < 2) begin
            m_err = sat(m_err); m_code = 3;
        end else begin
            c = 8'h00;
            for (int i = 0; i < n; i++) c = crc_step(c, cur[i]);
            if (c != 8'h00) begin
                m_err = sat(m_err); m_code = 1;
            end else begin
                m_ok = sat(m_ok);
                for (int i = 0; i < n - 1; i++)
                    exp_q.push_back('{d: cur[i], u: (i == 0), l: (i == n - 2), flen: n - 1});
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input logic u, input logic l);
        if (!in_frame) begin
            if (u) begin
                cur.delete(); cur.push_back(b); in_frame = 1; movf = 0;
                if (l) model_end();
            end
        end else if (movf) begin
            if (l) model_end();
        end else if (u) begin
            m_err = sat(m_err); m_code = 3;
            cur.delete(); cur.push_back(b);
            if (l) model_end();
        end else begin
            if (cur.size() == DEPTH) movf = 1;
            else cur.push_back(b);
            if (l) model_end();
        end
    endtask

    task automatic model_reset();
        exp_q.delete(); cur.delete();
        in_frame = 0; movf = 0; m_ok = 0; m_err = 0; m_code = 0;
    endtask

    task automatic drive(input logic [7:0] b, input logic u, input logic l);
        int k;
        k = 0;
        if (gap_en && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk_32M768);
        @(negedge clk_32M768);
        s_tdata = b; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && k < 4000) begin
            @(negedge clk_32M768);
            k++;
        end
        if (!s_tready) begin
            check("s_tready_timeout", 32'd0, 32'd1);
            s_tvalid = 1'b0;
            return;
        end
        @(posedge clk_32M768);
        model_byte(b, u, l);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic send_fbuf();
        for (int i = 0; i < fbuf.size(); i++)
            drive(fbuf[i], i == 0, i == fbuf.size() - 1);
    endtask

    task automatic build_good(input int n);
        logic [7:0] c;
        fbuf.delete();
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            fbuf.push_back(8'($urandom_range(0, 255)));
            c = crc_step(c, fbuf[i]);
        end
        fbuf.push_back(c);
    endtask

    task automatic settle();
        int k;
        k = 0;
        @(negedge clk_32M768);
        while (!(exp_q.size() == 0 && s_tready && !m_tvalid) && k < 5000) begin
            @(negedge clk_32M768);
            k++;
        end
        if (k >= 5000) begin
            check("settle_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        check("ok_cnt", ok_cnt, m_ok);
        check("err_cnt", err_cnt, m_err);
        check("err_code", err_code, m_code);
    endtask

    // output monitor: checks every beat, stalled stability, and drives m_tready
    initial begin : mon
        exp_t       e;
        logic [7:0] hd;
        logic       hu, hl;
        bit         stalled;
        stalled = 0; hd = 8'h00; hu = 1'b0; hl = 1'b0;
        forever begin
            @(negedge clk_32M768);
            if (!rst_n_32M768) begin
                stalled  = 0;
                m_tready = 1'b1;
            end else begin
                if (stalled)
                    check("stall_hold", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, hu, hl, hd});
                if (m_tvalid)
                    check("s_tready_in_send", s_tready, 1'b0);
                m_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (m_tvalid && m_tready) begin
                    out_log.push_back(m_tdata);
                    n_out++;
                    if (exp_q.size() == 0)
                        check("unexpected_out", 32'd1, 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        check("out_beat", {m_tuser, m_tlast, m_tdata}, {e.u, e.l, e.d});
                        if (e.u) check("frame_len", frame_len, e.flen);
                    end
                end
                stalled = m_tvalid && !m_tready;
                hd = m_tdata; hu = m_tuser; hl = m_tlast;
            end
        end
    end

    initial begin : main
        int k, n0, kind, plen;
        repeat (3) @(negedge clk_32M768);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_flags", {m_tlast, m_tuser}, 2'b00);
        check("rst_m_tdata", m_tdata, 8'h00);
        check("rst_frame_len", frame_len, 0);
        check("rst_counters", {ok_cnt, err_cnt}, 32'd0);
        check("rst_err_code", err_code, 2'b00);
        rst_n_32M768 = 1'b1;
        repeat (2) @(negedge clk_32M768);

        // "123456789" + 0xF4: good, latency 2
        fbuf.delete();
        for (int i = 0; i < 9; i++) fbuf.push_back(8'h31 + 8'(i));
        fbuf.push_back(8'hF4);
        out_log.delete();
        send_fbuf();
        @(negedge clk_32M768); check("lat_check_cycle", m_tvalid, 1'b0);
        @(negedge clk_32M768); check("lat_prefetch_cycle", m_tvalid, 1'b0);
        @(negedge clk_32M768); check("lat_first_valid", m_tvalid, 1'b1);
        settle();
        check("t1_out_count", out_log.size(), 9);
        for (int i = 0; i < 9 && i < out_log.size(); i++) check("t1_byte", out_log[i], 8'h31 + 8'(i));
        check("t1_ok_cnt", ok_cnt, 16'd1);
        check("t1_frame_len", frame_len, 9);

        // same frame with 0xF5: CRC drop
        fbuf[9] = 8'hF5;
        out_log.delete();
        send_fbuf();
        @(negedge clk_32M768); check("drop_check_s_tready", s_tready, 1'b0);
        @(negedge clk_32M768); check("drop_idle_s_tready", {s_tready, m_tvalid}, 2'b10);
        settle();
        check("t2_no_output", out_log.size(), 0);
        check("t2_err", {err_cnt, 14'd0, err_code}, {16'd1, 14'd0, 2'b01});

        // 257-byte overflow, then [01,02,1B]
        fbuf.delete();
        for (int i = 0; i < DEPTH + 1; i++) fbuf.push_back(8'($urandom_range(0, 255)));
        send_fbuf();
        settle();
        check("t3_err", {err_cnt, 14'd0, err_code}, {16'd2, 14'd0, 2'b10});
        fbuf.delete();
        fbuf.push_back(8'h01); fbuf.push_back(8'h02); fbuf.push_back(8'h1B);
        out_log.delete();
        send_fbuf();
        settle();
        check("t3_small_count", out_log.size(), 2);
        if (out_log.size() == 2) check("t3_small_bytes", {out_log[0], out_log[1]}, 16'h0102);
        check("t3_ok_cnt", ok_cnt, 16'd2);

        // single byte with tuser and tlast: short
        fbuf.delete(); fbuf.push_back(8'hA5);
        send_fbuf();
        settle();
        check("t4_err", {err_cnt, 14'd0, err_code}, {16'd3, 14'd0, 2'b11});

        // abandoned frame restarted by tuser
        for (int i = 0; i < 5; i++) drive(8'($urandom_range(0, 255)), i == 0, 1'b0);
        build_good(6);
        out_log.delete();
        send_fbuf();
        settle();
        check("t5_err_cnt", err_cnt, 16'd4);
        check("t5_ok_cnt", ok_cnt, 16'd3);
        check("t5_out_count", out_log.size(), 6);

        // maximum-length frame: BUF_DEPTH bytes including CRC
        build_good(DEPTH - 1);
        send_fbuf();
        settle();
        check("t6_frame_len", frame_len, DEPTH - 1);
        check("t6_ok_cnt", ok_cnt, 16'd4);

        // 200-byte payload under random backpressure
        bp_en = 1;
        build_good(200);
        out_log.delete();
        send_fbuf();
        settle();
        check("t7_out_count", out_log.size(), 200);
        bp_en = 0;

        // reset while sending
        build_good(30);
        send_fbuf();
        n0 = n_out; k = 0;
        while (n_out < n0 + 5 && k < 2000) begin
            @(negedge clk_32M768);
            k++;
        end
        check("t8_send_started", n_out >= n0 + 5, 1'b1);
        @(negedge clk_32M768);
        #2 rst_n_32M768 = 1'b0;
        model_reset();
        #1;
        check("t8_rst_m_out", {m_tvalid, m_tlast, m_tuser, m_tdata}, 11'd0);
        check("t8_rst_counters", {ok_cnt, err_cnt}, 32'd0);
        check("t8_rst_misc", {s_tready, err_code, 7'd0, frame_len}, {1'b1, 2'b00, 7'd0, 9'd0});
        repeat (2) @(negedge clk_32M768);
        rst_n_32M768 = 1'b1;
        build_good(4);
        send_fbuf();
        settle();
        check("t8_ok_after_reset", ok_cnt, 16'd1);

        // randomized traffic
        gap_en = 1; bp_en = 1;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            plen = $urandom_range(1, 40);
            case (kind)
                4: begin
                    build_good(plen);
                    fbuf[plen] = fbuf[plen] ^ 8'($urandom_range(1, 255));
                    send_fbuf();
                end
                5: drive(8'($urandom_range(0, 255)), 1'b1, 1'b1);
                6: begin
                    for (int i = 0; i < $urandom_range(1, 10); i++)
                        drive(8'($urandom_range(0, 255)), i == 0, 1'b0);
                    build_good(plen);
                    send_fbuf();
                end
                7: for (int i = 0; i < $urandom_range(1, 4); i++)
                       drive(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
                8: begin
                    fbuf.delete();
                    for (int i = 0; i < DEPTH + $urandom_range(1, 3); i++)
                        fbuf.push_back(8'($urandom_range(0, 255)));
                    send_fbuf();
                end
                9: begin
                    build_good(1);
                    send_fbuf();
                end
                default: begin
                    build_good(plen);
                    send_fbuf();
                end
            endcase
            if ($urandom_range(0, 1) == 0) settle();
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Receive-side frame buffer and CRC gate placed directly downstream of the depacketizer in the Rx chain, consuming its byte AXI-Stream (`data_tdata/tvalid/tlast/tuser`). It stores one frame at a time, checks a trailing CRC-8 byte, and replays only good frames, with the CRC byte stripped, on an output AXI-Stream. Bad, overflowing and truncated frames are dropped and counted, giving the flatten/host side a clean payload stream plus link-quality counters.

## Interface
- `BUF_DEPTH`, 256: frame buffer depth in bytes; power of two, minimum 4.
- `ADDR_W`, `$clog2(BUF_DEPTH)`: buffer address width; derived, never overridden.
- `MIN_LEN`, 2: minimum accepted frame length including the CRC byte.
- `clk_32M768`, in, 1: the block's only clock.
- `rst_n_32M768`, in, 1: asynchronous, active-low reset.
- `s_tdata`, in, 8: input byte.
- `s_tvalid`, in, 1: input byte valid; upstream may hold it low for any number of cycles.
- `s_tready`, out, 1: block can accept an input byte.
- `s_tlast`, in, 1: last byte of the frame (the CRC byte).
- `s_tuser`, in, 1: first byte of the frame.
- `m_tdata`, out, 8: output payload byte.
- `m_tvalid`, out, 1: output byte valid.
- `m_tready`, in, 1: downstream accepts the output byte.
- `m_tlast`, out, 1: last payload byte.
- `m_tuser`, out, 1: first payload byte.
- `frame_len`, out, ADDR_W+1: payload length of the frame being sent.
- `ok_cnt`, out, 16: good-frame count; saturates at 0xFFFF.
- `err_cnt`, out, 16: dropped-frame count; saturates at 0xFFFF.
- `err_code`, out, 2: cause of the last drop: 01 = CRC, 10 = overflow, 11 = short/truncated.

## Operation
- A byte is accepted on a rising edge with `s_tvalid & s_tready`. An output byte is accepted on a rising edge with `m_tvalid & m_tready`.
- CRC-8: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - The CRC runs over every stored byte, including the CRC byte.
  - A residue of 0x00 means the frame is good.
- The FSM has five states: IDLE, RECV, DROP, CHECK, SEND.
- `s_tready` = 1 in IDLE, RECV and DROP; 0 in CHECK and SEND.
- IDLE:
  - Accepted bytes with `s_tuser`=0 are discarded silently; nothing is counted.
  - An accepted byte with `s_tuser`=1 is stored at address 0, the CRC is loaded with that byte's update from init, len = 1, and the FSM goes to RECV.
  - If that byte also has `s_tlast`=1, the frame is short: next state is CHECK, which drops it with code 11.
- RECV:
  - Each accepted byte is stored at address len, updates the CRC, and len is incremented.
  - If len == BUF_DEPTH when a byte is accepted, the byte is not stored and the FSM goes to DROP (or directly to CHECK with the overflow flag set if that byte carries `s_tlast`).
  - An accepted byte with `s_tuser`=1 abandons the current frame: `err_cnt`+1, `err_code`=11, then the new frame starts at address 0 in the same cycle.
  - An accepted byte with `s_tlast`=1 moves the FSM to CHECK.
- DROP: accepted bytes are discarded until an accepted `s_tlast`, then the FSM goes to CHECK with the overflow flag set.
- CHECK takes one cycle and applies the first matching rule:
  - overflow flag set: `err_cnt`+1, `err_code`=10, go to IDLE.
  - len < MIN_LEN: `err_cnt`+1, `err_code`=11, go to IDLE.
  - residue ≠ 0: `err_cnt`+1, `err_code`=01, go to IDLE.
  - otherwise: `ok_cnt`+1, `frame_len` = len−1, go to SEND.
- SEND:
  - Bytes at addresses 0 .. len−2 are presented in order.
  - `m_tuser`=1 on address 0; `m_tlast`=1 on address len−2.
  - After the `m_tlast` handshake the FSM goes to IDLE.
- Buffer: single-port synchronous RAM with registered read, BUF_DEPTH×8.
  - Read data is prefetched so consecutive output handshakes proceed back-to-back with no bubbles.

## Timing
- Reset values: state = IDLE, `s_tready`=1, `m_tvalid`=`m_tlast`=`m_tuser`=0, `m_tdata`=0, `frame_len`=0, `ok_cnt`=`err_cnt`=0, `err_code`=00. CRC, len and the overflow flag are all cleared.
- Latency: `m_tvalid` rises 2 cycles after the edge that accepted `s_tlast` (CHECK, then the prefetch read).
- A drop decision returns the FSM to IDLE 1 cycle after the `s_tlast` edge; `s_tready` is 1 in that cycle.
- After the final output handshake, `s_tready` = 1 in the next cycle.
- AXI-Stream output rule: while `m_tvalid` & !`m_tready`, `m_tdata`, `m_tlast` and `m_tuser` hold stable. `m_tvalid` never drops before its handshake.
- Counters update on the CHECK cycle edge and are visible the following cycle. For an abandoned frame, they update on the `s_tuser` edge.
- `frame_len` holds from CHECK until the next good frame.
- Reset mid-frame or mid-send: all outputs return to their reset values immediately. Partial data is lost, not counted, and never replayed.
- Maximum-length frame: len == BUF_DEPTH with `s_tlast` on byte BUF_DEPTH is accepted normally, since that byte is stored.

## Test plan
- Frame "123456789" (0x31..0x39) plus CRC 0xF4, `m_tready`=1 → 9 output bytes 0x31..0x39, `m_tuser` on 0x31, `m_tlast` on 0x39, `frame_len`=9, `ok_cnt`=1, first `m_tvalid` 2 cycles after `s_tlast`.
- Same frame with CRC 0xF5 → no output, `err_cnt`=1, `err_code`=01, `s_tready`=1 one cycle after `s_tlast`.
- 257-byte frame with BUF_DEPTH=256 → dropped, `err_code`=10. A following good 3-byte frame [0x01,0x02,CRC 0x1B] outputs 0x01,0x02.
- Single byte with `s_tuser`=`s_tlast`=1 → `err_code`=11. A frame restarted by `s_tuser` mid-frame → `err_cnt`+1, and the new frame passes.
- Random `m_tready` backpressure on a 200-byte good frame → all bytes in order, and outputs stay stable while stalled; `s_tready`=0 throughout SEND.
- Reset asserted during SEND → `m_tvalid`=0 immediately, counters 0. A subsequent good frame passes with `ok_cnt`=1.
